// File: rtl/arf_variance_pipe.sv
// arf_variance_pipe: eight-stage signed multiply/accumulate pipeline computing
// out_27/out_28 from eight samples, with a valid/ready handshake on both sides
// and a wrapping count of delivered results.
module arf_variance_pipe #(
  parameter int                        DATA_W = 16,
  parameter int                        ACC_W  = 64,
  parameter logic signed [DATA_W-1:0]  COEF   = DATA_W'(3),
  parameter logic signed [ACC_W-1:0]   K13    = '0,
  parameter logic signed [ACC_W-1:0]   K14    = '0,
  parameter int                        CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_1,
  input  logic signed [DATA_W-1:0] in_2,
  input  logic signed [DATA_W-1:0] in_3,
  input  logic signed [DATA_W-1:0] in_4,
  input  logic signed [DATA_W-1:0] in_5,
  input  logic signed [DATA_W-1:0] in_6,
  input  logic signed [DATA_W-1:0] in_7,
  input  logic signed [DATA_W-1:0] in_8,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_27,
  output logic signed [ACC_W-1:0]  out_28,
  output logic [CNT_W-1:0]         result_count
);

  // Negation wraps within DATA_W, so the most negative COEF maps to itself.
  localparam logic signed [DATA_W-1:0] NEG_COEF = -COEF;

  // Full-precision DATA_W x DATA_W product, sign-extended to the accumulator width.
  function automatic logic signed [ACC_W-1:0] mul_op(
    input logic signed [DATA_W-1:0] op,
    input logic signed [DATA_W-1:0] c
  );
    logic signed [2*DATA_W-1:0] prod;
    prod = (2*DATA_W)'(op) * (2*DATA_W)'(c);
    return ACC_W'(prod);
  endfunction

  // Multiplier fed from an accumulator node: only its low DATA_W bits are used.
  function automatic logic signed [ACC_W-1:0] mul_node(
    input logic signed [ACC_W-1:0]  node,
    input logic signed [DATA_W-1:0] c
  );
    logic signed [DATA_W-1:0] op;
    op = DATA_W'(node);
    return mul_op(op, c);
  endfunction

  logic                     advance;
  logic signed [DATA_W-1:0] x [8];

  logic vld_p1, vld_p2, vld_p3, vld_p4, vld_p5, vld_p6, vld_p7, vld_p8;

  logic signed [ACC_W-1:0] p_p1 [8];
  logic signed [ACC_W-1:0] s9_p2, s10_p2, s11_p2, s12_p2;
  logic signed [ACC_W-1:0] s13_p3, s14_p3, s9_p3, s12_p3;
  logic signed [ACC_W-1:0] m15_p4, m16_p4, m17_p4, m18_p4, s9_p4, s12_p4;
  logic signed [ACC_W-1:0] s19_p5, s20_p5, s9_p5, s12_p5;
  logic signed [ACC_W-1:0] m21_p6, m22_p6, m23_p6, m24_p6, s9_p6, s12_p6;
  logic signed [ACC_W-1:0] s25_p7, s26_p7, s9_p7, s12_p7;
  logic signed [ACC_W-1:0] out27_p8, out28_p8;

  assign x[0] = in_1;
  assign x[1] = in_2;
  assign x[2] = in_3;
  assign x[3] = in_4;
  assign x[4] = in_5;
  assign x[5] = in_6;
  assign x[6] = in_7;
  assign x[7] = in_8;

  // The whole pipeline moves as one unit; it only stalls when a result is
  // waiting at the output and the consumer is not taking it.
  assign advance   = !vld_p8 || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_p8;
  assign out_27    = out27_p8;
  assign out_28    = out28_p8;

  // Valid bits travel with their data; bubbles shift through as zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      vld_p4 <= 1'b0;
      vld_p5 <= 1'b0;
      vld_p6 <= 1'b0;
      vld_p7 <= 1'b0;
      vld_p8 <= 1'b0;
    end else if (advance) begin
      vld_p1 <= in_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      vld_p4 <= vld_p3;
      vld_p5 <= vld_p4;
      vld_p6 <= vld_p5;
      vld_p7 <= vld_p6;
      vld_p8 <= vld_p7;
    end
  end

  // ---- S1: scale every sample by C ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) p_p1[i] <= '0;
    end else if (advance) begin
      for (int i = 0; i < 8; i++) p_p1[i] <= mul_op(x[i], COEF);
    end
  end

  // ---- S2: pairwise sums s9..s12 ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s9_p2  <= '0;
      s10_p2 <= '0;
      s11_p2 <= '0;
      s12_p2 <= '0;
    end else if (advance) begin
      s9_p2  <= p_p1[0] + p_p1[1];
      s10_p2 <= p_p1[2] + p_p1[3];
      s11_p2 <= p_p1[4] + p_p1[5];
      s12_p2 <= p_p1[6] + p_p1[7];
    end
  end

  // ---- S3: add the node offsets; s9/s12 start their delay line ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s13_p3 <= '0;
      s14_p3 <= '0;
      s9_p3  <= '0;
      s12_p3 <= '0;
    end else if (advance) begin
      s13_p3 <= s10_p2 + K13;
      s14_p3 <= s11_p2 + K14;
      s9_p3  <= s9_p2;
      s12_p3 <= s12_p2;
    end
  end

  // ---- S4: scale s13/s14 by C (m17/m18 duplicate m15/m16 by definition) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m15_p4 <= '0;
      m16_p4 <= '0;
      m17_p4 <= '0;
      m18_p4 <= '0;
      s9_p4  <= '0;
      s12_p4 <= '0;
    end else if (advance) begin
      m15_p4 <= mul_node(s13_p3, COEF);
      m16_p4 <= mul_node(s14_p3, COEF);
      m17_p4 <= mul_node(s13_p3, COEF);
      m18_p4 <= mul_node(s14_p3, COEF);
      s9_p4  <= s9_p3;
      s12_p4 <= s12_p3;
    end
  end

  // ---- S5: combine the scaled terms ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s19_p5 <= '0;
      s20_p5 <= '0;
      s9_p5  <= '0;
      s12_p5 <= '0;
    end else if (advance) begin
      s19_p5 <= m15_p4 + m16_p4;
      s20_p5 <= m17_p4 + m18_p4;
      s9_p5  <= s9_p4;
      s12_p5 <= s12_p4;
    end
  end

  // ---- S6: second multiply layer, mostly by -C ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m21_p6 <= '0;
      m22_p6 <= '0;
      m23_p6 <= '0;
      m24_p6 <= '0;
      s9_p6  <= '0;
      s12_p6 <= '0;
    end else if (advance) begin
      m21_p6 <= mul_node(s19_p5, NEG_COEF);
      m22_p6 <= mul_node(s20_p5, NEG_COEF);
      m23_p6 <= mul_node(s19_p5, NEG_COEF);
      m24_p6 <= mul_node(s20_p5, COEF);
      s9_p6  <= s9_p5;
      s12_p6 <= s12_p5;
    end
  end

  // ---- S7: fold the second layer ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s25_p7 <= '0;
      s26_p7 <= '0;
      s9_p7  <= '0;
      s12_p7 <= '0;
    end else if (advance) begin
      s25_p7 <= m21_p6 + m22_p6;
      s26_p7 <= m23_p6 + m24_p6;
      s9_p7  <= s9_p6;
      s12_p7 <= s12_p6;
    end
  end

  // ---- S8: final sums with the delay-matched s9/s12 ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out27_p8 <= '0;
      out28_p8 <= '0;
    end else if (advance) begin
      out27_p8 <= s9_p7 + s25_p7;
      out28_p8 <= s12_p7 + s26_p7;
    end
  end

  // Count completed output handshakes, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_count <= '0;
    end else if (out_valid && out_ready) begin
      result_count <= result_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_arf_variance_pipe.sv
// Testbench for arf_variance_pipe: directed table of hand-computed vectors,
// streaming/stall/reset/wrap sequences against a small dataflow model.
module tb_arf_variance_pipe;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] xin [8];
  logic               out_valid;
  logic               out_ready;
  logic signed [63:0] out_27;
  logic signed [63:0] out_28;
  logic [15:0]        result_count;

  logic               in_ready4;
  logic               out_valid4;
  logic signed [63:0] o27_4;
  logic signed [63:0] o28_4;
  logic [3:0]         cnt4;

  int n_chk;
  int n_fail;

  arf_variance_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_1(xin[0]), .in_2(xin[1]), .in_3(xin[2]), .in_4(xin[3]),
    .in_5(xin[4]), .in_6(xin[5]), .in_7(xin[6]), .in_8(xin[7]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_27(out_27), .out_28(out_28), .result_count(result_count)
  );

  arf_variance_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_1(xin[0]), .in_2(xin[1]), .in_3(xin[2]), .in_4(xin[3]),
    .in_5(xin[4]), .in_6(xin[5]), .in_7(xin[6]), .in_8(xin[7]),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_27(o27_4), .out_28(o28_4), .result_count(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] x [8];
    logic signed [63:0] e27;
    logic signed [63:0] e28;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: x_i*C with the low-16-bit operand rule for internal nodes.
  function automatic logic signed [63:0] mc(input logic signed [63:0] a, input logic signed [15:0] c);
    logic signed [15:0] lo;
    lo = a[15:0];
    return longint'(lo) * longint'(c);
  endfunction

  function automatic void model(input logic signed [15:0] x [8],
                                output logic signed [63:0] o27, output logic signed [63:0] o28);
    logic signed [63:0] p [8];
    logic signed [63:0] s9, s10, s11, s12, s13, s14, m15, m16, s19, s20;
    logic signed [63:0] m21, m22, m24, s25, s26;
    for (int j = 0; j < 8; j++) p[j] = longint'(x[j]) * 3;
    s9  = p[0] + p[1];
    s10 = p[2] + p[3];
    s11 = p[4] + p[5];
    s12 = p[6] + p[7];
    s13 = s10;
    s14 = s11;
    m15 = mc(s13, 16'sd3);
    m16 = mc(s14, 16'sd3);
    s19 = m15 + m16;
    s20 = m15 + m16;
    m21 = mc(s19, -16'sd3);
    m22 = mc(s20, -16'sd3);
    m24 = mc(s20, 16'sd3);
    s25 = m21 + m22;
    s26 = m21 + m24;
    o27 = s9 + s25;
    o28 = s12 + s26;
  endfunction

  function automatic void gen(input int i, output logic signed [15:0] x [8]);
    for (int j = 0; j < 8; j++) x[j] = 16'(i * 12345 + j * 7777 + (i ^ j) * 311 - 30000);
  endfunction

  // Single set through an empty pipe; reports edges from acceptance to output.
  task automatic run_vec(input logic signed [15:0] v [8], output logic signed [63:0] o27,
                         output logic signed [63:0] o28, output int lat);
    xin = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    o27 = out_27;
    o28 = out_28;
    step();
  endtask

  task automatic stream(input int n, input int base);
    logic signed [15:0] v [8];
    logic signed [63:0] e27, e28;
    int rx, last_c;
    rx = 0;
    last_c = -1;
    out_ready = 1'b1;
    for (int c = 0; c < n + 20; c++) begin
      if (out_valid) begin
        gen(base + rx, v);
        model(v, e27, e28);
        chk($sformatf("stream%0d_o27", rx), out_27, e27);
        chk($sformatf("stream%0d_o28", rx), out_28, e28);
        chk($sformatf("stream%0d_cnt4dut_o27", rx), o27_4, e27);
        chk($sformatf("stream%0d_cnt4dut_vld", rx), 64'(out_valid4), 64'd1);
        if (rx > 0) chk($sformatf("stream%0d_gap", rx), c, last_c + 1);
        last_c = c;
        rx++;
      end
      if (c < n) begin
        gen(base + c, v);
        xin = v;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    chk("stream_result_total", rx, n);
  endtask

  initial begin
    logic signed [15:0] v [8];
    logic signed [63:0] g27, g28, e27, e28;
    logic signed [63:0] exp27 [5];
    logic signed [63:0] exp28 [5];
    int lat, w;
    bit seen;

    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) xin[j] = '0;

    tbl[0].x = '{16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1};
    tbl[0].e27 = -64'sd210;  tbl[0].e28 = 64'sd6;
    tbl[1].x = '{-16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    tbl[1].e27 = -64'sd3;    tbl[1].e28 = 64'sd0;
    tbl[2].x = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    tbl[2].e27 = 64'sd0;     tbl[2].e28 = 64'sd0;
    tbl[3].x = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd2};
    tbl[3].e27 = 64'sd0;     tbl[3].e28 = 64'sd6;
    tbl[4].x = '{16'sd0, 16'sd0, 16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    tbl[4].e27 = -64'sd54;   tbl[4].e28 = 64'sd0;
    tbl[5].x = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd1, 16'sd0, 16'sd0, 16'sd0};
    tbl[5].e27 = -64'sd54;   tbl[5].e28 = 64'sd0;
    tbl[6].x = '{16'sd0, 16'sd100, 16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd5, 16'sd0};
    tbl[6].e27 = 64'sd300;   tbl[6].e28 = -64'sd15;
    tbl[7].x = '{16'sd0, 16'sd0, 16'sd20000, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    tbl[7].e27 = 64'sd99648; tbl[7].e28 = 64'sd0;
    tbl[8].x = '{16'sh8000, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    tbl[8].e27 = -64'sd98304; tbl[8].e28 = 64'sd0;

    // Reset state
    step();
    step();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_27", out_27, 64'sd0);
    chk("reset_out_28", out_28, 64'sd0);
    chk("reset_count", 64'(result_count), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    step();

    // Directed table, one set at a time
    for (int i = 0; i < 9; i++) begin
      run_vec(tbl[i].x, g27, g28, lat);
      chk($sformatf("vec%0d_latency", i), lat, 8);
      chk($sformatf("vec%0d_o27", i), g27, tbl[i].e27);
      chk($sformatf("vec%0d_o28", i), g28, tbl[i].e28);
      if (i == 0) chk("vec0_result_count", 64'(result_count), 64'd1);
    end

    // Back-pressure: five sets in flight, stall on first result
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      gen(100 + k, v);
      model(v, e27, e28);
      exp27[k] = e27;
      exp28[k] = e28;
      xin = v;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      step();
      w++;
    end
    chk("stall_first_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b0;
    for (int h = 0; h < 4; h++) begin
      step();
      chk($sformatf("stall%0d_in_ready", h), 64'(in_ready), 64'd0);
      chk($sformatf("stall%0d_o27", h), out_27, exp27[0]);
      chk($sformatf("stall%0d_o28", h), out_28, exp28[0]);
    end
    out_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      chk($sformatf("drain%0d_valid", r), 64'(out_valid), 64'd1);
      chk($sformatf("drain%0d_o27", r), out_27, exp27[r]);
      chk($sformatf("drain%0d_o28", r), out_28, exp28[r]);
      step();
    end
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("count_after_stall", 64'(result_count), 64'd14);

    // 20 back-to-back sets
    stream(20, 1000);
    chk("count_after_stream", 64'(result_count), 64'd34);
    chk("count4_after_stream", 64'(cnt4), 64'd2);

    // Reset with three sets in flight
    for (int k = 0; k < 3; k++) begin
      gen(500 + k, v);
      xin = v;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_27", out_27, 64'sd0);
    chk("midrst_out_28", out_28, 64'sd0);
    chk("midrst_count", 64'(result_count), 64'd0);
    chk("midrst_count4", 64'(cnt4), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    step();
    step();
    rst = 1'b0;
    chk("postrst_in_ready4", 64'(in_ready4), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("postrst_no_ghost", 64'(seen), 64'd0);

    // Counter wrap on the CNT_W=4 instance
    stream(17, 2000);
    chk("wrap_count16", 64'(result_count), 64'd17);
    chk("wrap_count4", 64'(cnt4), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
